lsu_data_port: RTL and testbench
================================

Name: lsu_data_port

Overview:
- CPU-side initiator for the data-memory interface (m_data_addr / m_data_rdata / m_data_wdata / m_data_byteen).
- The existing bench memory is the responder on that interface.
- Takes load/store requests from the EX stage and drives the memory bus from a registered M stage.
- Aligns and extends load data, then presents a registered GRF writeback (w_grf_* / w_inst_addr).

Parameters:
DM_BYTES, 16384, size of data memory in bytes; addresses >= DM_BYTES fault
PC_RESET, 32'h0000_3000, value driven on m_inst_addr / w_inst_addr when idle or in reset

Ports:
clk  in  1  system clock, all state on posedge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  EX presents a memory op
req_ready  out  1  request accepted this edge when req_valid && req_ready
req_op  in  3  0=LW 1=LH 2=LHU 3=LB 4=LBU 5=SW 6=SH 7=SB
req_addr  in  32  byte address
req_wdata  in  32  store data (low bytes used for SH/SB)
req_rd  in  5  load destination register
req_pc  in  32  PC of the instruction
stall  in  1  freeze M and W registers
flush  in  1  kill M-stage contents
m_data_addr  out  32  bus address (full byte address)
m_data_rdata  in  32  combinational read word at m_data_addr[31:2]
m_data_wdata  out  32  store data, lane-replicated
m_data_byteen  out  4  byte write enables; the responder writes on posedge when nonzero
m_inst_addr  out  32  PC of M-stage op
w_grf_we  out  1  writeback enable
w_grf_addr  out  5  writeback register
w_grf_wdata  out  32  extended load data
w_inst_addr  out  32  PC of W-stage op
fault  out  1  one-cycle flag: M-stage op misaligned or out of range

Behaviour:
- Reset (reset==0, async):
  - M and W valid bits cleared.
  - m_data_addr = 0, m_data_wdata = 0, m_data_byteen = 0, w_grf_we = 0, w_grf_addr = 0, w_grf_wdata = 0, fault = 0.
  - m_inst_addr = w_inst_addr = PC_RESET.
- req_ready = !stall.
- M register:
  - Loads {valid, op, addr, wdata, rd, pc} on posedge when !stall.
  - valid_next = req_valid && !flush.
  - flush has priority over an incoming request: both the M contents and the new request are dropped.
- M-stage bus drive (combinational from M register):
  - m_data_addr = M.addr; m_inst_addr = M.pc.
  - SW: byteen 4'b1111, wdata = data.
  - SH: byteen 4'b0011 << addr[1:0], wdata = {2{data[15:0]}}.
  - SB: byteen 4'b0001 << addr[1:0], wdata = {4{data[7:0]}}.
  - Loads: byteen = 0.
- Fault:
  - fault = M.valid && (LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0, or addr >= DM_BYTES).
  - A faulting op drives byteen = 0 and produces no writeback.
- byteen is forced to 0 when !M.valid or stall, so a held store never commits twice. The store commits at the first non-stalled edge while in M.
- Load extract from m_data_rdata in M:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- W register:
  - Loads on posedge when !stall.
  - w_grf_we = M.valid && load && !fault && rd!=0.
  - w_grf_wdata = extracted value; w_grf_addr = M.rd; w_inst_addr = M.pc.
  - When M is invalid: w_grf_we = 0, w_inst_addr = PC_RESET.
- Latency, for a request accepted at edge N:
  - Bus is driven from just after N.
  - Store commits at edge N+1.
  - Load writeback is visible just after N+1 and is sampled by the GRF/bench at N+2.
- Throughput: one op per cycle, back-to-back. A load following a store to the same word in the next cycle sees the committed data, because the store commits at the edge that moves the load into M.
- stall:
  - M and W hold their values, but W outputs still present.
  - w_grf_we is held, so the consumer must gate its write with stall.
  - fault is still computed; byteen is 0.
- flush while stall: flush is ignored. Stall wins, the pipeline stays frozen and flush must be reasserted.
- Reset mid-operation: an in-flight store in M is discarded. No write occurs, since byteen is 0 during reset.

Test Plan:
- After reset release: SW addr 0x10 data 0xDEADBEEF -> byteen 1111, addr 0x10 in cycle N+1; then LW 0x10 rd=8 -> w_grf_we=1, $8 <= 0xDEADBEEF.
- SB addr 0x13 data 0x000000A5 -> byteen 1000, wdata 0xA5A5A5A5; then LB 0x13 rd=9 -> 0xFFFFFFA5 and LBU -> 0x000000A5.
- SH addr 0x22 data 0x8001 -> byteen 1100, wdata 0x80018001; then LH 0x22 -> 0xFFFF8001 and LHU 0x22 -> 0x00008001.
- LW addr 0x31 and SW addr 0x4000 (DM_BYTES=16384):
  - LW addr 0x31 -> fault=1 for one cycle, w_grf_we=0.
  - SW addr 0x4000 -> fault=1, byteen=0.
- Store in M with stall held 3 cycles -> byteen 0 throughout, single commit on release; flush with a load in M -> no writeback.
- Assert reset (low) while SW is in M -> no memory write, all outputs at reset values asynchronously.

Source files
------------

// File: rtl/lsu_data_port.sv
// Load/store data port: registers EX requests into M, drives the data bus from M,
// and registers aligned/extended load data into W for GRF writeback.
module lsu_data_port #(
  parameter int unsigned DM_BYTES = 16384,
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_pc,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] m_data_addr,
  input  logic [31:0] m_data_rdata,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic [31:0] m_inst_addr,
  output logic        w_grf_we,
  output logic [4:0]  w_grf_addr,
  output logic [31:0] w_grf_wdata,
  output logic [31:0] w_inst_addr,
  output logic        fault
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [31:0] DM_LIMIT = 32'(DM_BYTES);

  // Handshake: a request is taken on a posedge where req_valid && req_ready;
  // req_ready is simply !stall, so the producer must hold its request while stalled.
  assign req_ready = !stall;

  logic        m_valid_q, m_valid_d;
  logic [2:0]  m_op_q;
  logic [31:0] m_addr_q;
  logic [31:0] m_wdata_q;
  logic [4:0]  m_rd_q;
  logic [31:0] m_pc_q;

  logic        w_we_q, w_we_d;
  logic [4:0]  w_addr_q;
  logic [31:0] w_wdata_q, w_wdata_d;
  logic [31:0] w_pc_q, w_pc_d;

  logic        m_is_load;
  logic        m_misaligned;
  logic        m_fault;
  logic [3:0]  byteen_raw;
  logic [31:0] wdata_rep;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign m_valid_d = req_valid && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid_q <= 1'b0;
      m_op_q    <= OP_LW;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_rd_q    <= '0;
      m_pc_q    <= PC_RESET;
    end else if (!stall) begin
      m_valid_q <= m_valid_d;
      m_op_q    <= req_op;
      m_addr_q  <= req_addr;
      m_wdata_q <= req_wdata;
      m_rd_q    <= req_rd;
      m_pc_q    <= req_pc;
    end
  end

  assign m_is_load = (m_op_q <= OP_LBU);

  always_comb begin
    m_misaligned = 1'b0;
    case (m_op_q)
      OP_LW, OP_SW:         m_misaligned = (m_addr_q[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: m_misaligned = m_addr_q[0];
      default:              m_misaligned = 1'b0;
    endcase
  end

  assign m_fault = m_valid_q && (m_misaligned || (m_addr_q >= DM_LIMIT));
  assign fault   = m_fault;

  always_comb begin
    byteen_raw = 4'b0000;
    wdata_rep  = m_wdata_q;
    case (m_op_q)
      OP_SW: begin
        byteen_raw = 4'b1111;
        wdata_rep  = m_wdata_q;
      end
      OP_SH: begin
        byteen_raw = 4'b0011 << m_addr_q[1:0];
        wdata_rep  = {2{m_wdata_q[15:0]}};
      end
      OP_SB: begin
        byteen_raw = 4'b0001 << m_addr_q[1:0];
        wdata_rep  = {4{m_wdata_q[7:0]}};
      end
      default: begin
        byteen_raw = 4'b0000;
        wdata_rep  = m_wdata_q;
      end
    endcase
  end

  // Gating with stall keeps a held store from committing on every frozen edge.
  assign m_data_byteen = (m_valid_q && !stall && !m_fault) ? byteen_raw : 4'b0000;
  assign m_data_wdata  = wdata_rep;
  assign m_data_addr   = m_addr_q;
  assign m_inst_addr   = m_valid_q ? m_pc_q : PC_RESET;

  always_comb begin
    ld_byte = m_data_rdata[7:0];
    case (m_addr_q[1:0])
      2'd0:    ld_byte = m_data_rdata[7:0];
      2'd1:    ld_byte = m_data_rdata[15:8];
      2'd2:    ld_byte = m_data_rdata[23:16];
      default: ld_byte = m_data_rdata[31:24];
    endcase
    ld_half = m_addr_q[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];
    ld_ext  = m_data_rdata;
    case (m_op_q)
      OP_LW:   ld_ext = m_data_rdata;
      OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_ext = {16'h0000, ld_half};
      OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_ext = {24'h000000, ld_byte};
      default: ld_ext = '0;
    endcase
  end

  // A flush drops the op sitting in M, so it must not reach writeback either.
  always_comb begin
    w_we_d    = m_valid_q && !flush && m_is_load && !m_fault && (m_rd_q != 5'd0);
    w_wdata_d = ld_ext;
    w_pc_d    = (m_valid_q && !flush) ? m_pc_q : PC_RESET;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_we_q    <= 1'b0;
      w_addr_q  <= '0;
      w_wdata_q <= '0;
      w_pc_q    <= PC_RESET;
    end else if (!stall) begin
      w_we_q    <= w_we_d;
      w_addr_q  <= m_rd_q;
      w_wdata_q <= w_wdata_d;
      w_pc_q    <= w_pc_d;
    end
  end

  assign w_grf_we    = w_we_q;
  assign w_grf_addr  = w_addr_q;
  assign w_grf_wdata = w_wdata_q;
  assign w_inst_addr = w_pc_q;

endmodule

// File: tb/tb_lsu_data_port.sv
// Directed bench for lsu_data_port with a word-addressed responder memory.
module tb_lsu_data_port;

  localparam logic [31:0] PC_RST = 32'h0000_3000;
  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4;
  localparam logic [2:0] SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic [31:0] req_pc = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] m_data_addr, m_data_rdata, m_data_wdata, m_inst_addr;
  logic [3:0]  m_data_byteen;
  logic        w_grf_we, fault;
  logic [4:0]  w_grf_addr;
  logic [31:0] w_grf_wdata, w_inst_addr;

  logic [31:0] mem [0:4095];
  int          wr_cnt;
  int          total = 0;
  int          bad = 0;
  int          base;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  lsu_data_port #(.DM_BYTES(16384), .PC_RESET(PC_RST)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd), .req_pc(req_pc),
    .stall(stall), .flush(flush),
    .m_data_addr(m_data_addr), .m_data_rdata(m_data_rdata),
    .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
    .m_inst_addr(m_inst_addr),
    .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr), .w_grf_wdata(w_grf_wdata),
    .w_inst_addr(w_inst_addr), .fault(fault)
  );

  assign m_data_rdata = mem[m_data_addr[13:2]];

  // Responder memory: byte-enabled write on posedge
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    wr_cnt = 0;
    forever begin
      @(posedge clk);
      if (m_data_byteen != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (m_data_byteen[b]) mem[m_data_addr[13:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge: apply inputs, cross one posedge, return at next negedge
  task automatic issue(input logic v, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] pc);
    req_valid = v;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    req_rd    = rd;
    req_pc    = pc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    issue(1'b0, LW, 32'h0, 32'h0, 5'd0, 32'h0);
  endtask

  task automatic check_wb(input string tag, input logic [4:0] rd, input logic [31:0] pc);
    logic [31:0] e;
    e = exp_q.pop_front();
    check({tag, "_we"}, 32'(w_grf_we), 32'd1);
    check({tag, "_addr"}, 32'(w_grf_addr), 32'(rd));
    check({tag, "_data"}, w_grf_wdata, e);
    check({tag, "_pc"}, w_inst_addr, pc);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_addr", m_data_addr, 32'h0);
    check("rst_wdata", m_data_wdata, 32'h0);
    check("rst_byteen", 32'(m_data_byteen), 32'h0);
    check("rst_we", 32'(w_grf_we), 32'h0);
    check("rst_waddr", 32'(w_grf_addr), 32'h0);
    check("rst_wdata_w", w_grf_wdata, 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_m_pc", m_inst_addr, PC_RST);
    check("rst_w_pc", w_inst_addr, PC_RST);
    check("rst_ready", 32'(req_ready), 32'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // SW then LW same word
    issue(1'b1, SW, 32'h10, 32'hDEADBEEF, 5'd0, 32'h100);
    check("sw_byteen", 32'(m_data_byteen), 32'hF);
    check("sw_addr", m_data_addr, 32'h10);
    check("sw_wdata", m_data_wdata, 32'hDEADBEEF);
    check("sw_pc", m_inst_addr, 32'h100);
    check("sw_fault", 32'(fault), 32'h0);
    exp_q.push_back(32'hDEADBEEF);
    issue(1'b1, LW, 32'h10, 32'h0, 5'd8, 32'h104);
    check("lw_byteen", 32'(m_data_byteen), 32'h0);
    check("sw_mem", mem[4], 32'hDEADBEEF);
    check("sw_no_wb", 32'(w_grf_we), 32'h0);
    idle();
    check_wb("lw", 5'd8, 32'h104);
    check("idle_m_pc", m_inst_addr, PC_RST);

    // SB then LB / LBU
    issue(1'b1, SB, 32'h13, 32'h000000A5, 5'd0, 32'h108);
    check("sb_byteen", 32'(m_data_byteen), 32'h8);
    check("sb_wdata", m_data_wdata, 32'hA5A5A5A5);
    exp_q.push_back(32'hFFFFFFA5);
    exp_q.push_back(32'h000000A5);
    issue(1'b1, LB, 32'h13, 32'h0, 5'd9, 32'h10C);
    issue(1'b1, LBU, 32'h13, 32'h0, 5'd10, 32'h110);
    check_wb("lb", 5'd9, 32'h10C);
    idle();
    check_wb("lbu", 5'd10, 32'h110);
    check("sb_mem", mem[4], 32'hA5ADBEEF);

    // SH then LH / LHU
    issue(1'b1, SH, 32'h22, 32'h00008001, 5'd0, 32'h114);
    check("sh_byteen", 32'(m_data_byteen), 32'hC);
    check("sh_wdata", m_data_wdata, 32'h80018001);
    exp_q.push_back(32'hFFFF8001);
    exp_q.push_back(32'h00008001);
    issue(1'b1, LH, 32'h22, 32'h0, 5'd11, 32'h118);
    issue(1'b1, LHU, 32'h22, 32'h0, 5'd12, 32'h11C);
    check_wb("lh", 5'd11, 32'h118);
    idle();
    check_wb("lhu", 5'd12, 32'h11C);
    check("sh_mem", mem[8], 32'h80010000);

    // Faults: misaligned LW, out-of-range SW
    base = wr_cnt;
    issue(1'b1, LW, 32'h31, 32'h0, 5'd13, 32'h200);
    check("lwmis_fault", 32'(fault), 32'h1);
    issue(1'b1, SW, 32'h4000, 32'h11111111, 5'd0, 32'h204);
    check("swoor_fault", 32'(fault), 32'h1);
    check("swoor_byteen", 32'(m_data_byteen), 32'h0);
    check("lwmis_no_wb", 32'(w_grf_we), 32'h0);
    idle();
    check("fault_clear", 32'(fault), 32'h0);
    check("fault_no_wr", 32'(wr_cnt), 32'(base));

    // Store held in M under stall: single commit on release
    base = wr_cnt;
    issue(1'b1, SW, 32'h40, 32'h12345678, 5'd0, 32'h300);
    check("st_byteen_pre", 32'(m_data_byteen), 32'hF);
    stall = 1'b1;
    req_valid = 1'b0;
    #1;
    check("st_ready", 32'(req_ready), 32'h0);
    check("st_byteen_0", 32'(m_data_byteen), 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("st_hold_byteen", 32'(m_data_byteen), 32'h0);
      check("st_hold_mem", mem[16], 32'h0);
    end
    stall = 1'b0;
    #1;
    check("st_rel_byteen", 32'(m_data_byteen), 32'hF);
    @(posedge clk);
    @(negedge clk);
    check("st_mem", mem[16], 32'h12345678);
    check("st_one_write", 32'(wr_cnt), 32'(base + 1));
    check("st_after_byteen", 32'(m_data_byteen), 32'h0);

    // Flush a load in M: no writeback
    issue(1'b1, LW, 32'h40, 32'h0, 5'd14, 32'h310);
    flush = 1'b1;
    idle();
    flush = 1'b0;
    check("flush_no_wb", 32'(w_grf_we), 32'h0);
    check("flush_w_pc", w_inst_addr, PC_RST);
    exp_q.push_back(32'h12345678);
    issue(1'b1, LW, 32'h40, 32'h0, 5'd15, 32'h314);
    idle();
    check_wb("lw_after_flush", 5'd15, 32'h314);

    // Reset while a store sits in M
    base = wr_cnt;
    req_valid = 1'b1;
    req_op    = SW;
    req_addr  = 32'h50;
    req_wdata = 32'hCAFEF00D;
    req_pc    = 32'h400;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_byteen", 32'(m_data_byteen), 32'h0);
    check("arst_addr", m_data_addr, 32'h0);
    check("arst_wdata", m_data_wdata, 32'h0);
    check("arst_m_pc", m_inst_addr, PC_RST);
    check("arst_w_pc", w_inst_addr, PC_RST);
    check("arst_wdata_w", w_grf_wdata, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("arst_mem", mem[20], 32'h0);
    check("arst_no_wr", 32'(wr_cnt), 32'(base));
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
